// File: rtl/apb_image_loader.sv
// APB image loader: streams source words into consecutive APB write transfers starting at base_addr.
// Optional feature macro APB_LOADER_GO_EN appends a write of 1 to Ctrl_Addr before done on every load.
module apb_image_loader #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 13,
  parameter int Ctrl_Addr       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [Amba_Addr_Depth-1:0] base_addr,
  input  logic [Amba_Addr_Depth-1:0] num_words,
  input  logic [Amba_Word-1:0]       src_data,
  input  logic                       src_valid,
  output logic                       src_ready,
  output logic [Amba_Addr_Depth-1:0] PADDR,
  output logic [Amba_Word-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic                       PREADY,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SETUP,
    ACCESS,
`ifdef APB_LOADER_GO_EN
    GO_SETUP,
    GO_ACCESS,
`endif
    DONE
  } state_t;

  // State entered once the data words are exhausted (or immediately for an empty load).
`ifdef APB_LOADER_GO_EN
  localparam state_t TAIL_STATE = GO_SETUP;
`else
  localparam state_t TAIL_STATE = DONE;
`endif

  state_t                     state;
  state_t                     next_state;
  logic [Amba_Addr_Depth-1:0] addr_cnt;
  logic [Amba_Addr_Depth-1:0] remaining;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    src_ready  = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    PWRITE     = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (num_words != '0) ? WAIT_DATA : TAIL_STATE;
        end
      end
      WAIT_DATA: begin
        src_ready = 1'b1;
        if (src_valid) begin
          next_state = SETUP;
        end
      end
      SETUP: begin
        PSEL       = 1'b1;
        PWRITE     = 1'b1;
        next_state = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        if (PREADY) begin
          next_state = (remaining > Amba_Addr_Depth'(1)) ? WAIT_DATA : TAIL_STATE;
        end
      end
`ifdef APB_LOADER_GO_EN
      GO_SETUP: begin
        PSEL       = 1'b1;
        PWRITE     = 1'b1;
        next_state = GO_ACCESS;
      end
      GO_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        if (PREADY) begin
          next_state = DONE;
        end
      end
`endif
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // PADDR/PWDATA are loaded on the cycle before SETUP so they are stable for the whole transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_cnt  <= '0;
      remaining <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_cnt  <= base_addr;
            remaining <= num_words;
          end
        end
        WAIT_DATA: begin
          if (src_valid) begin
            PWDATA <= src_data;
            PADDR  <= addr_cnt;
          end
        end
        ACCESS: begin
          if (PREADY) begin
            addr_cnt  <= addr_cnt + 1'b1;
            remaining <= remaining - 1'b1;
          end
        end
        default: begin
        end
      endcase
`ifdef APB_LOADER_GO_EN
      if (next_state == GO_SETUP) begin
        PADDR  <= Amba_Addr_Depth'(Ctrl_Addr);
        PWDATA <= Amba_Word'(1);
      end
`endif
    end
  end

endmodule
